// File: rtl/barr_pkg.sv
// Shared definitions for the barrier sequencers.
//   estado_t             : sequencer FSM states
//   MATR_W_DEF           : default licence-plate width
//   CNT_W_DEF            : default cycle-counter width
//   TIMEOUT_ABERTA_DEF   : default max open cycles without a passage
package barr_pkg;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    ABERTA = 2'd1,
    FECHO  = 2'd2
  } estado_t;

  localparam int unsigned MATR_W_DEF         = 24;
  localparam int unsigned CNT_W_DEF          = 7;
  localparam int unsigned TIMEOUT_ABERTA_DEF = 100;

endpackage

// File: rtl/fila_matr.sv
// Synchronous plate FIFO, DEPTH x MATR_W, pointers one bit wider than the
// address so full and empty are distinguishable.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_data    : plate to enqueue
//   wr_en      : enqueue request (dropped when full)
//   rd_en      : dequeue request (ignored when empty)
//   rd_data    : head of the queue
//   vazia      : queue empty
//   cheia      : queue full (registered)
//   descarte   : one-cycle pulse after a write was dropped on a full queue
module fila_matr #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MATR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MATR_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [MATR_W-1:0] rd_data,
  output logic              vazia,
  output logic              cheia,
  output logic              descarte
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_CHEIA = {1'b1, {AW{1'b0}}};

  logic [MATR_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [AW:0]       wr_ptr_d, rd_ptr_d;
  logic              push, pop;

  // Full comes from the registered flag, so a write against a full queue is
  // refused even when a read frees a slot on the same edge.
  assign push  = wr_en & ~cheia;
  assign pop   = rd_en & ~vazia;
  assign vazia = (wr_ptr == rd_ptr);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    if (push) wr_ptr_d = wr_ptr + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cheia    <= 1'b0;
      descarte <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      cheia    <= ((wr_ptr_d - rd_ptr_d) == CNT_CHEIA);
      descarte <= wr_en & cheia;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/seq_barr_2.sv
// Upstream sequencer for barrier 2: queues plates, opens the barrier for one
// plate at a time and times the open (ABERTA) and closing (FECHO) windows.
//   clk, rst_n          : clock, asynchronous active-low reset
//   matr_in/_val        : plate from the reader and its one-cycle strobe
//   passagem            : car-passed sensor (level)
//   ciclos_fechado_cfg  : requested closing-window length
//   Matricula/MatrVal   : plate being served and its valid flag
//   conta_ciclos        : cycle count within ABERTA/FECHO
//   ciclos_fechado      : closing-window length latched on FECHO entry
//   aberta              : barrier open command
//   fila_cheia          : plate FIFO full
//   descartada          : pulse, plate dropped on a full FIFO
module seq_barr_2
  import barr_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MATR_W         = MATR_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_ABERTA = TIMEOUT_ABERTA_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MATR_W-1:0] matr_in,
  input  logic              matr_in_val,
  input  logic              passagem,
  input  logic [CNT_W-1:0]  ciclos_fechado_cfg,
  output logic [MATR_W-1:0] Matricula,
  output logic              MatrVal,
  output logic [CNT_W-1:0]  conta_ciclos,
  output logic [CNT_W-1:0]  ciclos_fechado,
  output logic              aberta,
  output logic              fila_cheia,
  output logic              descartada
);

  localparam logic [CNT_W-1:0] LIM_ABERTA = CNT_W'(TIMEOUT_ABERTA - 1);

  estado_t           estado, prox_estado;
  logic [MATR_W-1:0] cabeca;
  logic              vazia;
  logic              pop;
  logic              latch_cfg;
  logic              fim_aberta, fim_fecho;
  logic [CNT_W-1:0]  conta_inc, conta_d;

  fila_matr #(
    .DEPTH  (DEPTH),
    .MATR_W (MATR_W)
  ) u_fila (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (matr_in),
    .wr_en    (matr_in_val),
    .rd_en    (pop),
    .rd_data  (cabeca),
    .vazia    (vazia),
    .cheia    (fila_cheia),
    .descarte (descartada)
  );

  // Saturating increment: holds at all-ones instead of wrapping.
  assign conta_inc  = (conta_ciclos == '1) ? conta_ciclos : conta_ciclos + 1'b1;
  assign fim_aberta = passagem || (conta_ciclos == LIM_ABERTA);
  assign fim_fecho  = (conta_ciclos == ciclos_fechado);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= ESPERA;
    else        estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      ESPERA:  if (!vazia)    prox_estado = ABERTA;
      ABERTA:  if (fim_aberta) prox_estado = FECHO;
      FECHO:   if (fim_fecho)  prox_estado = ESPERA;
      default:                 prox_estado = ESPERA;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    latch_cfg = 1'b0;
    conta_d   = '0;
    case (estado)
      ESPERA: pop = !vazia;
      ABERTA: begin
        if (fim_aberta) latch_cfg = 1'b1;
        else            conta_d   = conta_inc;
      end
      FECHO:  if (!fim_fecho) conta_d = conta_inc;
      default: ;
    endcase
  end

  // aberta/MatrVal are decoded from the state register, so an async reset
  // drops them at once without passing through FECHO.
  assign aberta  = (estado == ABERTA);
  assign MatrVal = (estado != ESPERA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Matricula      <= '0;
      conta_ciclos   <= '0;
      ciclos_fechado <= '0;
    end else begin
      conta_ciclos <= conta_d;
      if (pop)       Matricula      <= cabeca;
      if (latch_cfg) ciclos_fechado <= ciclos_fechado_cfg;
    end
  end

endmodule

// File: tb/tb_seq_barr_2.sv
module tb_seq_barr_2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] matr_in = '0;
  logic        matr_in_val = 1'b0;
  logic        passagem = 1'b0;
  logic [6:0]  ciclos_fechado_cfg = '0;
  logic [23:0] Matricula;
  logic        MatrVal;
  logic [6:0]  conta_ciclos;
  logic [6:0]  ciclos_fechado;
  logic        aberta;
  logic        fila_cheia;
  logic        descartada;

  int checks = 0;
  int failures = 0;
  logic [23:0] sb [$];
  logic [23:0] exp_m;
  bit mv_prev = 1'b0;

  seq_barr_2 #(
    .DEPTH          (4),
    .MATR_W         (24),
    .CNT_W          (7),
    .TIMEOUT_ABERTA (100)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .matr_in            (matr_in),
    .matr_in_val        (matr_in_val),
    .passagem           (passagem),
    .ciclos_fechado_cfg (ciclos_fechado_cfg),
    .Matricula          (Matricula),
    .MatrVal            (MatrVal),
    .conta_ciclos       (conta_ciclos),
    .ciclos_fechado     (ciclos_fechado),
    .aberta             (aberta),
    .fila_cheia         (fila_cheia),
    .descartada         (descartada)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Scoreboard: each start of service must present the oldest accepted plate.
  always @(negedge clk) begin
    if (!rst_n) mv_prev = 1'b0;
    else begin
      if (MatrVal && !mv_prev) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL served_order unexpected plate got=%h", Matricula);
        end else begin
          exp_m = sb.pop_front();
          if (Matricula !== exp_m) begin
            failures++;
            $display("FAIL served_order got=%h exp=%h", Matricula, exp_m);
          end
        end
      end
      mv_prev = MatrVal;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_plate(input logic [23:0] p, input bit acc);
    matr_in     = p;
    matr_in_val = 1'b1;
    if (acc) sb.push_back(p);
    step();
    matr_in_val = 1'b0;
  endtask

  task automatic wait_aberta(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (aberta === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (MatrVal === 1'b0 && aberta === 1'b0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({Matricula, MatrVal, conta_ciclos, ciclos_fechado, aberta, fila_cheia, descartada} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b/%0d/%0d/%b/%b/%b exp=all zero",
               Matricula, MatrVal, conta_ciclos, ciclos_fechado, aberta, fila_cheia, descartada);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int n_ab;
    int nf;
    ciclos_fechado_cfg = 7'd10;
    passagem = 1'b0;
    push_plate(24'hABC123, 1'b1);
    checks++;
    if (MatrVal !== 1'b0) begin
      failures++;
      $display("FAIL single_early got MatrVal=%b exp=0", MatrVal);
    end
    step();
    checks++;
    if (MatrVal !== 1'b1 || aberta !== 1'b1 || Matricula !== 24'hABC123) begin
      failures++;
      $display("FAIL single_latency got %b/%b/%h exp 1/1/abc123", MatrVal, aberta, Matricula);
    end
    n_ab = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (aberta === 1'b1) n_ab++;
      checks++;
      if (conta_ciclos !== 7'(k)) begin
        failures++;
        $display("FAIL single_count got=%0d exp=%0d", conta_ciclos, k);
      end
    end
    passagem = 1'b1;
    step();
    passagem = 1'b0;
    checks++;
    if (aberta !== 1'b0 || n_ab != 6) begin
      failures++;
      $display("FAIL single_open_len got aberta=%b cycles=%0d exp 0/6", aberta, n_ab);
    end
    checks++;
    if (ciclos_fechado !== 7'd10 || conta_ciclos !== 7'd0 || MatrVal !== 1'b1) begin
      failures++;
      $display("FAIL single_fecho_entry got cf=%0d cnt=%0d mv=%b exp 10/0/1",
               ciclos_fechado, conta_ciclos, MatrVal);
    end
    nf = 0;
    while (MatrVal === 1'b1 && nf < 200) begin
      nf++;
      step();
    end
    checks++;
    if (nf != 11 || conta_ciclos !== 7'd0) begin
      failures++;
      $display("FAIL single_fecho_len got=%0d cnt=%0d exp 11/0", nf, conta_ciclos);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    int maxc;
    ciclos_fechado_cfg = 7'd2;
    passagem = 1'b0;
    push_plate(24'h007100, 1'b1);
    wait_aberta(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_open got aberta=%b exp=1", aberta);
    end
    n = 0;
    maxc = 0;
    while (aberta === 1'b1 && n < 300) begin
      n++;
      if (int'(conta_ciclos) > maxc) maxc = int'(conta_ciclos);
      step();
    end
    checks++;
    if (n != 100 || maxc != 99) begin
      failures++;
      $display("FAIL timeout_len got cycles=%0d maxcnt=%0d exp 100/99", n, maxc);
    end
    checks++;
    if (conta_ciclos !== 7'd0 || MatrVal !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fecho_entry got cnt=%0d mv=%b exp 0/1", conta_ciclos, MatrVal);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_idle got MatrVal=%b exp=0", MatrVal);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n_desc;
    logic [23:0] p;
    ciclos_fechado_cfg = 7'd0;
    passagem = 1'b0;
    push_plate(24'h100000, 1'b1);
    wait_aberta(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_open got aberta=%b exp=1", aberta);
    end
    n_desc = 0;
    for (int i = 1; i <= 6; i++) begin
      p = 24'h100000 + 24'(i);
      push_plate(p, i <= 4);
      if (descartada === 1'b1) n_desc++;
      if (i == 4) begin
        checks++;
        if (fila_cheia !== 1'b1) begin
          failures++;
          $display("FAIL b2b_full got=%b exp=1", fila_cheia);
        end
      end
    end
    repeat (2) begin
      step();
      if (descartada === 1'b1) n_desc++;
    end
    checks++;
    if (n_desc != 2) begin
      failures++;
      $display("FAIL b2b_drops got=%0d exp=2", n_desc);
    end
    passagem = 1'b1;
    wait_idle(ok);
    passagem = 1'b0;
    checks++;
    if (!ok || fila_cheia !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got idle=%b full=%b pending=%0d exp 1/0/0", ok, fila_cheia, sb.size());
    end
  endtask

  task automatic test_cfg_zero();
    bit ok;
    ciclos_fechado_cfg = 7'd0;
    passagem = 1'b1;
    push_plate(24'h0A0A0A, 1'b1);
    push_plate(24'h0B0B0B, 1'b1);
    checks++;
    if (aberta !== 1'b1 || Matricula !== 24'h0A0A0A) begin
      failures++;
      $display("FAIL cfg0_first got %b/%h exp 1/0a0a0a", aberta, Matricula);
    end
    step();
    checks++;
    if (aberta !== 1'b0 || MatrVal !== 1'b1) begin
      failures++;
      $display("FAIL cfg0_aberta_len got aberta=%b mv=%b exp 0/1", aberta, MatrVal);
    end
    step();
    checks++;
    if (MatrVal !== 1'b0) begin
      failures++;
      $display("FAIL cfg0_fecho_len got mv=%b exp=0", MatrVal);
    end
    step();
    checks++;
    if (MatrVal !== 1'b1 || aberta !== 1'b1 || Matricula !== 24'h0B0B0B) begin
      failures++;
      $display("FAIL cfg0_next_pop got %b/%b/%h exp 1/1/0b0b0b", MatrVal, aberta, Matricula);
    end
    wait_idle(ok);
    passagem = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cfg0_idle got mv=%b exp=0", MatrVal);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    ciclos_fechado_cfg = 7'd5;
    passagem = 1'b0;
    push_plate(24'h200000, 1'b1);
    wait_aberta(ok);
    push_plate(24'h200001, 1'b0);
    push_plate(24'h200002, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({Matricula, MatrVal, conta_ciclos, ciclos_fechado, aberta, fila_cheia, descartada} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got %h/%b/%0d/%0d/%b/%b/%b exp all zero",
               Matricula, MatrVal, conta_ciclos, ciclos_fechado, aberta, fila_cheia, descartada);
    end
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (MatrVal !== 1'b0 || aberta !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_mid_fifo_empty got active_cycles=%0d exp=0", seen);
    end
    passagem = 1'b1;
    push_plate(24'h2FFFFF, 1'b1);
    wait_idle(ok);
    passagem = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_mid_resume got pending=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_cfg_change();
    bit ok;
    bit held;
    int nf;
    ciclos_fechado_cfg = 7'd10;
    passagem = 1'b1;
    push_plate(24'h300000, 1'b1);
    wait_aberta(ok);
    step();
    ciclos_fechado_cfg = 7'd3;
    passagem = 1'b0;
    checks++;
    if (aberta !== 1'b0 || ciclos_fechado !== 7'd10) begin
      failures++;
      $display("FAIL cfgchg_latch got aberta=%b cf=%0d exp 0/10", aberta, ciclos_fechado);
    end
    nf = 0;
    held = 1'b1;
    while (MatrVal === 1'b1 && nf < 200) begin
      nf++;
      if (ciclos_fechado !== 7'd10) held = 1'b0;
      step();
    end
    checks++;
    if (nf != 11 || !held) begin
      failures++;
      $display("FAIL cfgchg_fecho got len=%0d held=%b exp 11/1", nf, held);
    end
    passagem = 1'b1;
    push_plate(24'h300001, 1'b1);
    wait_aberta(ok);
    step();
    passagem = 1'b0;
    checks++;
    if (ciclos_fechado !== 7'd3) begin
      failures++;
      $display("FAIL cfgchg_next got=%0d exp=3", ciclos_fechado);
    end
    nf = 0;
    while (MatrVal === 1'b1 && nf < 200) begin
      nf++;
      step();
    end
    checks++;
    if (nf != 4) begin
      failures++;
      $display("FAIL cfgchg_next_len got=%0d exp=4", nf);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_back_to_back();
    test_cfg_zero();
    test_reset_mid();
    test_cfg_change();
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_barr_2.md
Name: seq_barr_2

Overview:
- Upstream sequencer for barrier 2 of the car-park gate.
- Buffers incoming licence plates, opens the barrier for one plate at a time, and times the open and closing windows.
- Drives the barrier-close stage with the current plate, its valid flag, the running cycle count and the latched closing-window length.
- Closing-window lengths up to 127 cycles; plates arriving while a car is being served are queued.

Parameters:
- DEPTH, 4, plate FIFO depth (power of two, minimum 2).
- MATR_W, 24, plate width in bits.
- CNT_W, 7, cycle counter width.
- TIMEOUT_ABERTA, 100, max open cycles without passage (1..2^CNT_W-1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- matr_in  in  MATR_W  plate from the reader.
- matr_in_val  in  1  single-cycle strobe: matr_in is valid.
- passagem  in  1  car-passed sensor, level, sampled each edge.
- ciclos_fechado_cfg  in  CNT_W  requested closing-window length.
- Matricula  out  MATR_W  plate currently being served.
- MatrVal  out  1  Matricula is valid (high from pop through end of FECHO).
- conta_ciclos  out  CNT_W  cycle count within the current ABERTA/FECHO state.
- ciclos_fechado  out  CNT_W  closing-window length latched on FECHO entry.
- aberta  out  1  barrier open command.
- fila_cheia  out  1  FIFO full.
- descartada  out  1  one-cycle pulse: plate dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, any state):
  - FIFO emptied; FSM goes to ESPERA.
  - Matricula=0, MatrVal=0, conta_ciclos=0, ciclos_fechado=0, aberta=0, fila_cheia=0, descartada=0.
  - A reset mid-ABERTA drops aberta immediately, with no FECHO phase.
- FIFO push:
  - Push when matr_in_val=1 and the FIFO is not full.
  - Full is evaluated before any same-edge pop. A push against a full FIFO is dropped even if a pop occurs on that edge, and descartada pulses on the next cycle.
  - fila_cheia is registered, equal to count==DEPTH.
- FSM states: ESPERA, ABERTA, FECHO.
- ESPERA:
  - aberta=0, conta_ciclos=0, MatrVal=0.
  - If the FIFO is non-empty on an edge: pop the head into Matricula, set MatrVal=1 and aberta=1, go to ABERTA.
  - Latency: plate sampled at edge N appears on Matricula/MatrVal/aberta after edge N+1, if the FIFO was empty and the FSM was in ESPERA.
  - A push and a pop on an empty FIFO on the same edge are impossible; the pop sees the pre-edge count.
- ABERTA:
  - conta_ciclos increments by 1 per edge, starting from 0.
  - Exit to FECHO on the first edge where passagem=1 or conta_ciclos==TIMEOUT_ABERTA-1. If both are true, the result is identical.
  - On exit: aberta=0, conta_ciclos=0, ciclos_fechado<=ciclos_fechado_cfg.
- FECHO:
  - aberta=0, MatrVal stays 1, Matricula held.
  - conta_ciclos increments per edge.
  - When conta_ciclos==ciclos_fechado: next edge goes to ESPERA with MatrVal=0 and conta_ciclos=0.
  - If ciclos_fechado=0, FECHO lasts exactly 1 cycle.
  - ciclos_fechado_cfg changes during FECHO are ignored.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - Saturates at 2^CNT_W-1 and never wraps. Wrap is unreachable given the parameter limits, but the saturation logic must still be present.
- passagem is ignored in ESPERA and FECHO.
- Pushes are accepted in every state.
- ciclos_fechado holds its value in ESPERA and ABERTA until the next FECHO entry.
- descartada may pulse in any state.

Decomposition:
- Package barr_pkg:
  - State enum (ESPERA=2'd0, ABERTA=2'd1, FECHO=2'd2).
  - MATR_W and CNT_W defaults.
  - Default TIMEOUT_ABERTA constant.
- Sub-module fila_matr:
  - Synchronous FIFO, DEPTH x MATR_W.
  - Read/write pointers one bit wider than the address.
  - Full/empty flags and a drop pulse.
- The top level holds the FSM, the counter and the output registers.

Test Plan:
- Single plate 24'hABC123, passagem high 5 cycles after aberta rises, cfg=10:
  - Matricula=24'hABC123 and MatrVal=1 one edge after the push is sampled.
  - aberta high 6 cycles.
  - ciclos_fechado=10.
  - FECHO lasts 11 cycles, then MatrVal=0.
- No passagem, TIMEOUT_ABERTA=100:
  - aberta drops after exactly 100 cycles (conta_ciclos reaches 99).
  - FECHO entered with conta_ciclos=0.
- Push 6 plates back-to-back while serving (DEPTH=4):
  - fila_cheia=1 after 4 queued.
  - Two descartada pulses.
  - Plates served in FIFO order; the dropped ones never appear on Matricula.
- cfg=0 with passagem on the first ABERTA cycle:
  - ABERTA lasts 1 cycle, FECHO lasts 1 cycle.
  - The next queued plate is popped on the following edge.
- rst_n asserted mid-ABERTA with 2 plates queued:
  - All outputs 0 immediately.
  - After release, the FIFO is empty and no plate is served until a new push.
- cfg changed from 10 to 3 during FECHO:
  - ciclos_fechado stays 10; FECHO still lasts 11 cycles.
  - The next service latches 3.
